// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline sequencer
package pipe_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [4:0]  REG_X0    = 5'd0;
    localparam int          TO_W      = 16;

endpackage

// File: rtl/pipe_hazard_detect.sv
// rtl/pipe_hazard_detect.sv - combinational load-use hazard compare between D and E
module pipe_hazard_detect
    import pipe_pkg::*;
(
    input  logic [4:0] rs1_addr_D,
    input  logic [4:0] rs2_addr_D,
    input  logic       rs1_used_D,
    input  logic       rs2_used_D,
    input  logic [4:0] rd_waddr_E,
    input  logic       mem_read_E,
    output logic       lu_hazard
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = rs1_used_D && (rs1_addr_D == rd_waddr_E);
    assign rs2_match = rs2_used_D && (rs2_addr_D == rd_waddr_E);

    // x0 is hard-wired zero, so a load targeting it can never feed a consumer
    assign lu_hazard = mem_read_E && (rd_waddr_E != REG_X0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 5-stage pipeline sequencer: stalls, squashes, dmem wait/timeout
// Optional perf counters built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_addr_D,
    input  logic [4:0]       rs2_addr_D,
    input  logic             rs1_used_D,
    input  logic             rs2_used_D,
    input  logic [4:0]       rd_waddr_E,
    input  logic             mem_read_E,
    input  logic             branch_taken_E,
    input  logic             mem_access_M,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             fd_en,
    output logic             fd_flush,
    output logic             de_en,
    output logic             de_flush,
    output logic             em_en,
    output logic             mr_en,
    output logic             mr_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t          state;
    logic [TO_W-1:0] wait_cnt;
    logic            lu_hazard;
    logic            timeout;
    logic            mem_stall;

    pipe_hazard_detect u_hazard (
        .rs1_addr_D (rs1_addr_D),
        .rs2_addr_D (rs2_addr_D),
        .rs1_used_D (rs1_used_D),
        .rs2_used_D (rs2_used_D),
        .rd_waddr_E (rd_waddr_E),
        .mem_read_E (mem_read_E),
        .lu_hazard  (lu_hazard)
    );

    assign timeout   = (state == MEM_WAIT) && !dmem_ready &&
                       (wait_cnt == TO_W'(MEM_TIMEOUT - 1));
    // A timeout releases the pipe like a completed access: the M instr retires as done
    assign mem_stall = (state == RUN) ? (mem_access_M && !dmem_ready)
                                      : (!dmem_ready && !timeout);

    always_comb begin
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        de_en    = 1'b1;
        em_en    = 1'b1;
        mr_en    = 1'b1;
        fd_flush = 1'b0;
        de_flush = 1'b0;
        mr_flush = 1'b0;
        dmem_req = mem_access_M || (state == MEM_WAIT);
        if (!rst_n) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
            mr_flush = 1'b1;
            dmem_req = 1'b0;
        end else if (mem_stall) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_en    = 1'b0;
            em_en    = 1'b0;
            mr_flush = 1'b1;
            dmem_req = 1'b1;
        end else if (branch_taken_E) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
        end else if (lu_hazard) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    wait_cnt <= '0;
                    if (mem_access_M && !dmem_ready) state <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (timeout) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                        mem_err  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_cnt    <= '0;
        end else begin
            if (!pc_en) stall_cycles <= stall_cycles + CNT_W'(1);
            if (branch_taken_E && !mem_stall) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl against a behavioural model
module tb_pipe_ctrl;
    localparam int T  = 4;
    localparam int CW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic [4:0] rs1_addr_D = '0, rs2_addr_D = '0, rd_waddr_E = '0;
    logic       rs1_used_D = 0, rs2_used_D = 0, mem_read_E = 0;
    logic       branch_taken_E = 0, mem_access_M = 0, dmem_ready = 0;
    logic       dmem_req, pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mr_en, mr_flush, mem_err;
    logic [CW-1:0] stall_cycles, flush_cnt;

    pipe_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
        .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D),
        .rd_waddr_E(rd_waddr_E), .mem_read_E(mem_read_E),
        .branch_taken_E(branch_taken_E), .mem_access_M(mem_access_M),
        .dmem_ready(dmem_ready), .dmem_req(dmem_req),
        .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush),
        .de_en(de_en), .de_flush(de_flush), .em_en(em_en),
        .mr_en(mr_en), .mr_flush(mr_flush), .mem_err(mem_err),
        .stall_cycles(stall_cycles), .flush_cnt(flush_cnt)
    );

    // {dmem_req, pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mr_en, mr_flush}
    wire [8:0] got = {dmem_req, pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mr_en, mr_flush};
    localparam logic [8:0] O_RESET  = 9'b011111111;
    localparam logic [8:0] O_IDLE   = 9'b011010110;
    localparam logic [8:0] O_FROZEN = 9'b100000011;
    localparam logic [8:0] O_LU     = 9'b000011110;
    localparam logic [8:0] O_BR     = 9'b011111110;

    int errors = 0;
    int checks = 0;

    bit            m_wait;
    int            m_wcnt;
    bit            m_err;
    logic [CW-1:0] m_stall, m_flush;

    function automatic logic [8:0] model_out();
        bit lu, frozen, br;
        if (!rst_n) return O_RESET;
        frozen = m_wait ? (!dmem_ready && m_wcnt != T - 1) : (mem_access_M && !dmem_ready);
        if (frozen) return O_FROZEN;
        lu = mem_read_E && rd_waddr_E != 0 &&
             ((rs1_used_D && rs1_addr_D == rd_waddr_E) || (rs2_used_D && rs2_addr_D == rd_waddr_E));
        br = branch_taken_E;
        return {m_wait || mem_access_M, br || !lu, br || !lu, br, 1'b1, br || lu, 1'b1, 1'b1, 1'b0};
    endfunction

    function automatic logic [CW-1:0] exp_stall();
`ifdef PIPE_CTRL_PERF_EN
        return m_stall;
`else
        return '0;
`endif
    endfunction

    function automatic logic [CW-1:0] exp_flush();
`ifdef PIPE_CTRL_PERF_EN
        return m_flush;
`else
        return '0;
`endif
    endfunction

    task automatic tick();
        logic [8:0] e;
        e = model_out();
        if (!rst_n) begin
            m_wait = 0; m_wcnt = 0; m_err = 0; m_stall = '0; m_flush = '0;
        end else begin
            if (!e[7]) m_stall = m_stall + 1;
            if (e[5])  m_flush = m_flush + 1;
            if (m_wait) begin
                if (dmem_ready) begin
                    m_wait = 0; m_wcnt = 0;
                end else if (m_wcnt == T - 1) begin
                    m_wait = 0; m_wcnt = 0; m_err = 1;
                end else begin
                    m_wcnt++;
                end
            end else if (mem_access_M && !dmem_ready) begin
                m_wait = 1; m_wcnt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs1_addr_D = 0; rs2_addr_D = 0; rs1_used_D = 0; rs2_used_D = 0;
        rd_waddr_E = 0; mem_read_E = 0; branch_taken_E = 0;
        mem_access_M = 0; dmem_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        mem_access_M = 1; branch_taken_E = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (got !== O_RESET) begin
                $display("FAIL reset_outputs cyc%0d: got=%b exp=%b", i, got, O_RESET); errors++;
            end
            checks++;
            tick();
        end
        rst_n = 1;
        idle_inputs();
        @(negedge clk);
        if (got !== O_IDLE) begin
            $display("FAIL post_reset_outputs: got=%b exp=%b", got, O_IDLE); errors++;
        end
        checks++;
        if (mem_err !== 1'b0) begin
            $display("FAIL post_reset_mem_err: got=%b exp=0", mem_err); errors++;
        end
        checks++;
        if (stall_cycles !== '0 || flush_cnt !== '0) begin
            $display("FAIL post_reset_counters: got=%0d/%0d exp=0/0", stall_cycles, flush_cnt); errors++;
        end
        checks++;
        tick();
    endtask

    task automatic test_load_use();
        mem_read_E = 1; rd_waddr_E = 5; rs1_addr_D = 5; rs1_used_D = 1;
        rs2_addr_D = 1; rs2_used_D = 1;
        @(negedge clk);
        if (got !== O_LU || got !== model_out()) begin
            $display("FAIL load_use_stall: got=%b exp=%b", got, O_LU); errors++;
        end
        checks++;
        tick();
        idle_inputs();
        @(negedge clk);
        if (got !== O_IDLE) begin
            $display("FAIL load_use_no_repeat: got=%b exp=%b", got, O_IDLE); errors++;
        end
        checks++;
        tick();
    endtask

    task automatic test_x0();
        mem_read_E = 1; rd_waddr_E = 0; rs1_addr_D = 0; rs1_used_D = 1;
        @(negedge clk);
        if (got !== O_IDLE) begin
            $display("FAIL x0_no_hazard: got=%b exp=%b", got, O_IDLE); errors++;
        end
        checks++;
        tick();
        idle_inputs();
    endtask

    task automatic test_mem_wait();
        mem_access_M = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (got !== O_FROZEN || got !== model_out()) begin
                $display("FAIL mem_wait_frozen cyc%0d: got=%b exp=%b", i, got, O_FROZEN); errors++;
            end
            checks++;
            tick();
        end
        dmem_ready = 1;
        @(negedge clk);
        if (got !== 9'b111010110) begin
            $display("FAIL mem_wait_release: got=%b exp=%b", got, 9'b111010110); errors++;
        end
        checks++;
        tick();
        idle_inputs();
        @(negedge clk);
        if (got !== O_IDLE) begin
            $display("FAIL mem_wait_back_to_run: got=%b exp=%b", got, O_IDLE); errors++;
        end
        checks++;
        tick();
    endtask

    task automatic test_branch();
        logic [CW-1:0] f0;
        f0 = flush_cnt;
        branch_taken_E = 1; mem_read_E = 1; rd_waddr_E = 7; rs2_addr_D = 7; rs2_used_D = 1;
        @(negedge clk);
        if (got !== O_BR) begin
            $display("FAIL branch_over_load_use: got=%b exp=%b", got, O_BR); errors++;
        end
        checks++;
        tick();
        idle_inputs();
        @(negedge clk);
`ifdef PIPE_CTRL_PERF_EN
        if (flush_cnt !== f0 + 1) begin
            $display("FAIL branch_flush_cnt: got=%0d exp=%0d", flush_cnt, f0 + 1); errors++;
        end
`else
        if (flush_cnt !== '0) begin
            $display("FAIL branch_flush_cnt: got=%0d exp=0", flush_cnt); errors++;
        end
`endif
        checks++;
        // branch arriving while dmem is stalled must wait for the release cycle
        branch_taken_E = 1; mem_access_M = 1; dmem_ready = 0;
        @(negedge clk);
        if (got !== O_FROZEN) begin
            $display("FAIL branch_held_in_stall: got=%b exp=%b", got, O_FROZEN); errors++;
        end
        checks++;
        tick();
        dmem_ready = 1;
        @(negedge clk);
        if (got !== 9'b111111110) begin
            $display("FAIL branch_on_release: got=%b exp=%b", got, 9'b111111110); errors++;
        end
        checks++;
        tick();
        idle_inputs();
    endtask

    task automatic test_timeout();
        mem_access_M = 1; dmem_ready = 0;
        for (int i = 0; i < T; i++) begin
            @(negedge clk);
            if (got !== O_FROZEN || mem_err !== 1'b0) begin
                $display("FAIL timeout_stall cyc%0d: got=%b err=%b exp=%b err=0", i, got, mem_err, O_FROZEN); errors++;
            end
            checks++;
            tick();
        end
        @(negedge clk);
        if (got !== 9'b111010110) begin
            $display("FAIL timeout_release: got=%b exp=%b", got, 9'b111010110); errors++;
        end
        checks++;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_err !== 1'b1 || got !== O_IDLE) begin
                $display("FAIL timeout_sticky cyc%0d: err=%b got=%b exp err=1 %b", i, mem_err, got, O_IDLE); errors++;
            end
            checks++;
            tick();
        end
        if (stall_cycles !== exp_stall()) begin
            $display("FAIL timeout_stall_cycles: got=%0d exp=%0d", stall_cycles, exp_stall()); errors++;
        end
        checks++;
        rst_n = 0;
        tick();
        rst_n = 1;
        @(negedge clk);
        if (mem_err !== 1'b0) begin
            $display("FAIL timeout_err_cleared: got=%b exp=0", mem_err); errors++;
        end
        checks++;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst_n          = ($urandom_range(0, 79) != 0);
            rs1_addr_D     = 5'($urandom_range(0, 3));
            rs2_addr_D     = 5'($urandom_range(0, 3));
            rd_waddr_E     = 5'($urandom_range(0, 3));
            rs1_used_D     = 1'($urandom);
            rs2_used_D     = 1'($urandom);
            mem_read_E     = 1'($urandom);
            branch_taken_E = ($urandom_range(0, 4) == 0);
            mem_access_M   = 1'($urandom);
            dmem_ready     = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            if (got !== model_out()) begin
                $display("FAIL random_outputs cyc%0d: got=%b exp=%b", i, got, model_out()); errors++;
            end
            checks++;
            if (mem_err !== m_err) begin
                $display("FAIL random_mem_err cyc%0d: got=%b exp=%b", i, mem_err, m_err); errors++;
            end
            checks++;
            if (stall_cycles !== exp_stall() || flush_cnt !== exp_flush()) begin
                $display("FAIL random_counters cyc%0d: got=%0d/%0d exp=%0d/%0d",
                         i, stall_cycles, flush_cnt, exp_stall(), exp_flush()); errors++;
            end
            checks++;
            tick();
        end
        rst_n = 1;
        idle_inputs();
    endtask

    initial begin
        m_wait = 0; m_wcnt = 0; m_err = 0; m_stall = '0; m_flush = '0;
        test_reset();
        test_load_use();
        test_x0();
        test_mem_wait();
        test_branch();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
